// File: rtl/div_pkg.sv
// Shared types and helpers for the fractional restoring divider.
package div_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_FRAC  = 16;
    localparam int DEF_ITERS = DEF_WIDTH + DEF_FRAC;

    // One quotient bit per dividend bit: the shifted-out numerator plus the fraction zeros.
    function automatic int iter_count(input int width, input int frac);
        return width + frac;
    endfunction

    // Two's-complement bit pattern of the saturation bound for a qw-bit result.
    // The min-negative pattern equals the largest legal negative magnitude, so one
    // value serves both as compare limit and as saturated result.
    function automatic logic [63:0] sat_limit(input int qw, input logic neg);
        logic [63:0] one;
        logic [63:0] top;
        one = 64'd1;
        top = one << (qw - 1);
        return neg ? top : top - 64'd1;
    endfunction

endpackage

// File: rtl/div_restore_step.sv
// Single combinational restoring-division step: shift in one dividend bit, trial subtract.
module div_restore_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] divisor,
    input  logic             bit_in,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;
    logic           unused_diff_msb;

    always_comb begin
        shifted  = {rem, bit_in};
        diff     = shifted - {1'b0, divisor};
        q_bit    = (shifted >= {1'b0, divisor});
        rem_next = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

    // After a successful subtract the result is below the divisor, so the MSB is always zero.
    assign unused_diff_msb = diff[WIDTH];

endmodule

// File: rtl/frac_div_pipe.sv
// Fixed-point divider floor(num * 2^FRAC / den), radix-2 restoring, one bit per cycle,
// with ready/valid handshakes, tag passthrough, divide-by-zero and overflow reporting.
module frac_div_pipe
    import div_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int FRAC   = 16,
    parameter int QW     = 16,
    parameter int SIGNED = 0,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] numerator,
    input  logic [WIDTH-1:0] denominator,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [QW-1:0]    quotient,
    output logic [WIDTH-1:0] remainder,
    output logic [TAG_W-1:0] out_tag,
    output logic             dbz,
    output logic             ovf
);

    localparam int N  = iter_count(WIDTH, FRAC);
    localparam int CW = $clog2(N + 1);
    localparam int XW = (N > QW) ? N : QW;
    localparam logic [63:0] LIM_POS = sat_limit(QW, 1'b0);
    localparam logic [63:0] LIM_NEG = sat_limit(QW, 1'b1);

    state_t state, state_nxt;

    logic [CW-1:0]    cnt;
    logic [N-1:0]     acc;       // dividend bits shift out the top, quotient bits shift in the bottom
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] den_mag;
    logic [WIDTH-1:0] num_raw;
    logic             res_neg;
    logic             num_neg;
    logic             dbz_pend;
    logic [TAG_W-1:0] tag_q;

    logic             accept;
    logic             last;
    logic [WIDTH-1:0] rem_nxt;
    logic             q_bit;

    // Operand decode: abs taken one bit wider so the most negative value has a magnitude.
    logic             num_sgn, den_sgn;
    logic [WIDTH:0]   num_x, den_x, num_abs, den_abs;
    logic             abs_unused;

    always_comb begin
        num_sgn = (SIGNED != 0) && numerator[WIDTH-1];
        den_sgn = (SIGNED != 0) && denominator[WIDTH-1];
        num_x   = {num_sgn, numerator};
        den_x   = {den_sgn, denominator};
        num_abs = num_sgn ? -num_x : num_x;
        den_abs = den_sgn ? -den_x : den_x;
    end

    assign abs_unused = num_abs[WIDTH] ^ den_abs[WIDTH];

    assign accept    = in_valid && (state == IDLE);
    assign last      = (state == RUN) && (cnt == CW'(1));
    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    div_restore_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem),
        .divisor (den_mag),
        .bit_in  (acc[N-1]),
        .rem_next(rem_nxt),
        .q_bit   (q_bit)
    );

    // Result formatting: overflow detect, sign restore and saturation.
    logic [N-1:0]     qmag;
    logic [XW-1:0]    qext;
    logic             upper;
    logic [QW-1:0]    low;
    logic [QW-1:0]    lim;
    logic             ovf_c;
    logic [QW-1:0]    q_c;
    logic [WIDTH-1:0] rem_c;
    logic [QW-1:0]    q_dbz;

    always_comb begin
        qmag  = {acc[N-2:0], q_bit};
        qext  = XW'(qmag);
        upper = (qext >> QW) != '0;
        low   = qext[QW-1:0];
        lim   = res_neg ? LIM_NEG[QW-1:0] : LIM_POS[QW-1:0];
        if (SIGNED != 0) begin
            ovf_c = upper || (low > lim);
            q_c   = ovf_c ? lim : (res_neg ? -low : low);
            rem_c = num_neg ? -rem_nxt : rem_nxt;
            if (num_raw == '0)
                q_dbz = '0;
            else
                q_dbz = num_neg ? LIM_NEG[QW-1:0] : LIM_POS[QW-1:0];
        end else begin
            ovf_c = upper;
            q_c   = ovf_c ? '1 : low;
            rem_c = rem_nxt;
            q_dbz = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)  state_nxt = RUN;
            RUN:     if (last)      state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            acc       <= '0;
            rem       <= '0;
            den_mag   <= '0;
            num_raw   <= '0;
            res_neg   <= 1'b0;
            num_neg   <= 1'b0;
            dbz_pend  <= 1'b0;
            tag_q     <= '0;
            quotient  <= '0;
            remainder <= '0;
            out_tag   <= '0;
            dbz       <= 1'b0;
            ovf       <= 1'b0;
        end else if (accept) begin
            // A zero divisor takes one dummy RUN cycle so dbz completes one edge after accept.
            cnt      <= (denominator == '0) ? CW'(1) : CW'(N);
            acc      <= N'(num_abs[WIDTH-1:0]) << FRAC;
            rem      <= '0;
            den_mag  <= den_abs[WIDTH-1:0];
            num_raw  <= numerator;
            res_neg  <= num_sgn ^ den_sgn;
            num_neg  <= num_sgn;
            dbz_pend <= (denominator == '0);
            tag_q    <= in_tag;
        end else if (state == RUN) begin
            cnt <= cnt - CW'(1);
            acc <= qmag;
            rem <= rem_nxt;
            if (last) begin
                quotient  <= dbz_pend ? q_dbz : q_c;
                remainder <= dbz_pend ? num_raw : rem_c;
                ovf       <= !dbz_pend && ovf_c;
                dbz       <= dbz_pend;
                out_tag   <= tag_q;
            end
        end
    end

endmodule
